// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
//   DEFAULT_DATA_W / DEFAULT_NUM_REGS : default parameter values
//   popcount()                        : number of set bits in a busy vector (up to MAX_REGS wide)
package reg_file_pkg;

  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam int unsigned DEFAULT_NUM_REGS = 16;
  localparam int unsigned MAX_REGS         = 64;
  localparam int unsigned CNT_MAX_W        = 7;

  // Shift-and-add so no variable bit index is needed.
  function automatic logic [CNT_MAX_W-1:0] popcount(input logic [MAX_REGS-1:0] v);
    logic [CNT_MAX_W-1:0] cnt;
    logic [MAX_REGS-1:0]  w;
    cnt = '0;
    w   = v;
    for (int unsigned i = 0; i < MAX_REGS; i++) begin
      cnt = cnt + CNT_MAX_W'(w[0]);
      w   = w >> 1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding writeback,
// decides whether an issue can be accepted and keeps a registered pending count.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   issue_valid                 issue request
//   rs1_addr, rs2_addr          source selects checked for hazards
//   dest_addr, dest_we          destination marked pending on accept
//   wb_valid, wb_addr           writeback clears the pending mark
//   flush                       clears every pending mark
//   issue_ready_c, accept_c     combinational handshake results
//   busy_cnt                    registered popcount of busy bits
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter bit          ZERO_REG = 1'b0,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS),
  localparam int unsigned CNT_W   = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              dest_we,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  output logic              issue_ready_c,
  output logic              accept_c,
  output logic [CNT_W-1:0]  busy_cnt
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] wb_clr_c;
  logic [NUM_REGS-1:0] busy_eff_c;
  logic [NUM_REGS-1:0] set_c;
  logic [NUM_REGS-1:0] busy_next_c;
  logic                hazard_c;
  logic                dest_ok_c;

  // Hazard check sees a same-cycle writeback as already retired.
  always_comb begin
    wb_clr_c      = wb_valid ? (NUM_REGS'(1) << wb_addr) : '0;
    busy_eff_c    = busy & ~wb_clr_c;
    hazard_c      = busy_eff_c[rs1_addr] | busy_eff_c[rs2_addr] |
                    (dest_we & busy_eff_c[dest_addr]);
    issue_ready_c = ~flush & ~hazard_c;
    accept_c      = issue_valid & issue_ready_c;
    dest_ok_c     = ~(ZERO_REG && (dest_addr == '0));
    set_c         = (accept_c & dest_we & dest_ok_c) ? (NUM_REGS'(1) << dest_addr) : '0;
    // Set is ORed after the clear so a new pending mark wins over a same-cycle writeback.
    busy_next_c   = flush ? '0 : ((busy & ~wb_clr_c) | set_c);
  end

  // Busy vector and its count update together so the count always matches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next_c;
      busy_cnt <= CNT_W'(popcount(MAX_REGS'(busy_next_c)));
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with issue scoreboard: two registered read ports with
// writeback bypass, one writeback port, and pending-destination tracking.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   issue_valid / issue_ready      issue handshake (ready is combinational)
//   rs1_addr, rs2_addr             source selects
//   dest_addr, dest_we             destination marked pending on accept
//   rs1_data, rs2_data, rd_valid   read data, valid one cycle after accept
//   wb_valid, wb_addr, wb_data     writeback port
//   flush                          clears all pending marks
//   busy_cnt                       number of pending registers
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter bit          ZERO_REG = 1'b0,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              dest_we,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rd_valid,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd1_c;
  logic [DATA_W-1:0] rd2_c;
  logic              accept_c;
  logic              wb_en_c;

  reg_file_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .dest_addr     (dest_addr),
    .dest_we       (dest_we),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .flush         (flush),
    .issue_ready_c (issue_ready),
    .accept_c      (accept_c),
    .busy_cnt      (busy_cnt)
  );

  // Source read with zero-register override first, then writeback bypass.
  always_comb begin
    wb_en_c = wb_valid & ~(ZERO_REG && (wb_addr == '0));
    if (ZERO_REG && (rs1_addr == '0))        rd1_c = '0;
    else if (wb_valid && (wb_addr == rs1_addr)) rd1_c = wb_data;
    else                                     rd1_c = regs[rs1_addr];
    if (ZERO_REG && (rs2_addr == '0))        rd2_c = '0;
    else if (wb_valid && (wb_addr == rs2_addr)) rd2_c = wb_data;
    else                                     rd2_c = regs[rs2_addr];
  end

  // Storage write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (wb_en_c) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Read registers hold between accepts; rd_valid pulses on the cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_data <= '0;
      rs2_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= accept_c;
      if (accept_c) begin
        rs1_data <= rd1_c;
        rs2_data <= rd2_c;
      end
    end
  end

endmodule
